rp_8bit_gpio_pcint: RTL and testbench

Parametrised successor to the team's 8-bit GPIO port peripheral on the AVR-compatible I/O bus.
- Adds configurable input synchroniser depth and per-pin rising/falling edge interrupts with a write-1-to-clear flag register.
- Adds AVR-style PORT toggle through PIN writes, plus sleep gating that keeps wake-capable pins alive.
- Sits on the core I/O bus; its irq output feeds the interrupt controller.

---
 rtl/rp_8bit_gpio_pcint_if.sv | 11 +
 rtl/rp_8bit_gpio_pcint.sv | 95 +++++++++
 tb/tb_rp_8bit_gpio_pcint.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/rp_8bit_gpio_pcint_if.sv
// Core I/O bus as seen by the GPIO port: one-hot strobes, write data and
// combinational read data.
interface rp_8bit_gpio_pcint_if;
    logic [5:0] io_re;
    logic [5:0] io_we;
    logic [7:0] io_dw;
    logic [7:0] io_dr;

    modport master (output io_re, output io_we, output io_dw, input io_dr);
    modport slave  (input io_re, input io_we, input io_dw, output io_dr);
endinterface

// File: rtl/rp_8bit_gpio_pcint.sv
// GPIO port with PIN/DDR/PORT, input synchroniser, per-pin edge interrupts
// with write-1-to-clear flags, PIN-write toggle and sleep input gating.
module rp_8bit_gpio_pcint #(
    parameter int         PDW = 8,
    parameter int         SYN = 2,
    parameter logic [5:0] ADR = 6'h00
) (
    input  logic                  clk,
    input  logic                  rst,
    rp_8bit_gpio_pcint_if.slave   bus,
    input  logic                  pud,
    input  logic                  sleep,
    output logic                  irq,
    output logic [PDW-1:0]        gpio_pull,
    output logic [PDW-1:0]        gpio_ddr,
    output logic [PDW-1:0]        gpio_port,
    input  logic [PDW-1:0]        gpio_pin
);

    if (PDW < 1 || PDW > 8 || SYN < 2 || $bits(ADR) != 6) begin : g_bad_cfg
        $error("rp_8bit_gpio_pcint: unsupported PDW/SYN");
    end

    logic [PDW-1:0] r_ddr;
    logic [PDW-1:0] r_port;
    logic [PDW-1:0] r_rise;
    logic [PDW-1:0] r_fall;
    logic [PDW-1:0] r_flag;
    logic [PDW-1:0] r_prev;
    logic [PDW-1:0] r_sync [SYN];
    logic           r_irq;

    logic [PDW-1:0] w_dw;
    logic [PDW-1:0] w_pin_g;
    logic [PDW-1:0] w_sync;
    logic [PDW-1:0] w_ev;
    logic [PDW-1:0] w_port_nxt;
    logic [PDW-1:0] w_flag_nxt;
    logic [7:0]     w_dr;

    assign w_dw   = bus.io_dw[PDW-1:0];
    assign w_sync = r_sync[SYN-1];

    // While asleep only pins with an edge enable keep toggling the synchroniser.
    assign w_pin_g = gpio_pin & (sleep ? (r_rise | r_fall) : {PDW{1'b1}});

    assign w_ev = (w_sync & ~r_prev & r_rise) | (~w_sync & r_prev & r_fall);

    // A PIN write toggles on top of whatever the PORT write (if any) loads.
    assign w_port_nxt = (bus.io_we[2] ? w_dw : r_port) ^ (bus.io_we[0] ? w_dw : '0);
    assign w_flag_nxt = (r_flag & ~(bus.io_we[5] ? w_dw : '0)) | w_ev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ddr  <= '0;
            r_port <= '0;
            r_rise <= '0;
            r_fall <= '0;
            r_flag <= '0;
            r_prev <= '0;
            r_irq  <= 1'b0;
            for (int i = 0; i < SYN; i++) r_sync[i] <= '0;
        end else begin
            if (bus.io_we[1]) r_ddr  <= w_dw;
            if (bus.io_we[3]) r_rise <= w_dw;
            if (bus.io_we[4]) r_fall <= w_dw;
            r_port    <= w_port_nxt;
            r_flag    <= w_flag_nxt;
            r_irq     <= |w_flag_nxt;
            r_prev    <= w_sync;
            r_sync[0] <= w_pin_g;
            for (int i = 1; i < SYN; i++) r_sync[i] <= r_sync[i-1];
        end
    end

    always_comb begin
        w_dr = 8'h00;
        case (bus.io_re)
            6'b000001: w_dr = 8'(w_sync);
            6'b000010: w_dr = 8'(r_ddr);
            6'b000100: w_dr = 8'(r_port);
            6'b001000: w_dr = 8'(r_rise);
            6'b010000: w_dr = 8'(r_fall);
            6'b100000: w_dr = 8'(r_flag);
            default:   w_dr = 8'h00;
        endcase
    end

    assign bus.io_dr = w_dr;
    assign irq       = r_irq;
    assign gpio_ddr  = r_ddr;
    assign gpio_port = r_port;
    assign gpio_pull = pud ? '0 : (~r_ddr & r_port);

endmodule

// File: tb/tb_rp_8bit_gpio_pcint.sv
// Directed bench for the GPIO port: default instance (PDW=8, SYN=2) plus a
// narrow, deeper-synchroniser instance (PDW=4, SYN=3).
module tb_rp_8bit_gpio_pcint;

  localparam int R_PIN  = 0;
  localparam int R_DDR  = 1;
  localparam int R_PORT = 2;
  localparam int R_RISE = 3;
  localparam int R_FALL = 4;
  localparam int R_FLAG = 5;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic       pud;
  logic       sleep;
  logic [7:0] pin_a;
  logic [3:0] pin_b;
  logic       irq_a, irq_b;
  logic [7:0] pull_a, ddr_a, port_a;
  logic [3:0] pull_b, ddr_b, port_b;

  int checks   = 0;
  int failures = 0;

  rp_8bit_gpio_pcint_if bus_a ();
  rp_8bit_gpio_pcint_if bus_b ();

  rp_8bit_gpio_pcint #(.PDW(8), .SYN(2), .ADR(6'h00)) u_dut_a (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_a.slave),
    .pud       (pud),
    .sleep     (sleep),
    .irq       (irq_a),
    .gpio_pull (pull_a),
    .gpio_ddr  (ddr_a),
    .gpio_port (port_a),
    .gpio_pin  (pin_a)
  );

  rp_8bit_gpio_pcint #(.PDW(4), .SYN(3), .ADR(6'h10)) u_dut_b (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_b.slave),
    .pud       (pud),
    .sleep     (sleep),
    .irq       (irq_b),
    .gpio_pull (pull_b),
    .gpio_ddr  (ddr_b),
    .gpio_port (port_b),
    .gpio_pin  (pin_b)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
    end
  endtask

  // driver tasks: all start and end in the negedge phase
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr_m(input bit sel, input logic [5:0] mask, input logic [7:0] d);
    if (!sel) begin
      bus_a.io_we = mask;
      bus_a.io_dw = d;
    end else begin
      bus_b.io_we = mask;
      bus_b.io_dw = d;
    end
    @(posedge clk);
    #1;
    bus_a.io_we = 6'b0;
    bus_b.io_we = 6'b0;
    @(negedge clk);
  endtask

  task automatic wr(input bit sel, input int idx, input logic [7:0] d);
    wr_m(sel, 6'(1 << idx), d);
  endtask

  task automatic rd_m_chk(input bit sel, input logic [5:0] mask, input string tag,
                          input logic [7:0] exp);
    logic [7:0] v;
    if (!sel) bus_a.io_re = mask;
    else      bus_b.io_re = mask;
    #1;
    v = sel ? bus_b.io_dr : bus_a.io_dr;
    bus_a.io_re = 6'b0;
    bus_b.io_re = 6'b0;
    chk(tag, v, exp);
  endtask

  task automatic rd_chk(input bit sel, input int idx, input string tag, input logic [7:0] exp);
    rd_m_chk(sel, 6'(1 << idx), tag, exp);
  endtask

  initial begin
    bus_a.io_re = 6'b0; bus_a.io_we = 6'b0; bus_a.io_dw = 8'h00;
    bus_b.io_re = 6'b0; bus_b.io_we = 6'b0; bus_b.io_dw = 8'h00;
    pud = 1'b0; sleep = 1'b0;
    pin_a = 8'hFF; pin_b = 4'h0;
    rst = 1'b0;
    cyc(3);

    // 1: reset state, PIN latency, pad held high gives no flag
    chk("rst_ddr",  ddr_a,  8'h00);
    chk("rst_port", port_a, 8'h00);
    chk("rst_pull", pull_a, 8'h00);
    chk("rst_irq",  {7'b0, irq_a}, 8'h00);
    rd_chk(0, R_PIN, "rst_pin_held", 8'h00);
    rst = 1'b1;
    cyc(1);
    rd_chk(0, R_PIN, "pin_lat_early", 8'h00);
    cyc(1);
    rd_chk(0, R_PIN, "pin_lat_syn", 8'hFF);
    cyc(8);
    rd_chk(0, R_FLAG, "rst_noflag", 8'h00);
    chk("rst_noirq", {7'b0, irq_a}, 8'h00);

    // 2: DDR/PORT, pull-ups, PIN toggle and PORT+PIN composition
    wr(0, R_DDR, 8'h0F);
    wr(0, R_PORT, 8'hA5);
    chk("pull_on", pull_a, 8'hA0);
    chk("port_out", port_a, 8'hA5);
    pud = 1'b1;
    #1;
    chk("pull_pud", pull_a, 8'h00);
    wr(0, R_PIN, 8'h03);
    rd_chk(0, R_PORT, "pin_toggle", 8'hA6);
    wr_m(0, 6'b000101, 8'h3C);
    rd_chk(0, R_PORT, "port_pin_same", 8'h00);
    pud = 1'b0;

    // 3: rising edge on pin0, exact flag latency, falling edge ignored
    wr(0, R_RISE, 8'h01);
    pin_a = 8'hFE;
    cyc(4);
    rd_chk(0, R_FLAG, "fall_no_rise", 8'h00);
    pin_a = 8'hFF;
    cyc(2);
    rd_chk(0, R_FLAG, "rise_early", 8'h00);
    chk("rise_irq_early", {7'b0, irq_a}, 8'h00);
    cyc(1);
    rd_chk(0, R_FLAG, "rise_flag", 8'h01);
    chk("rise_irq", {7'b0, irq_a}, 8'h01);
    pin_a = 8'hFE;
    cyc(5);
    rd_chk(0, R_FLAG, "rise_hold", 8'h01);
    wr(0, R_FLAG, 8'h01);
    rd_chk(0, R_FLAG, "rise_clr", 8'h00);

    // 4: falling edge on pin7, clear colliding with a new set
    wr(0, R_FALL, 8'h80);
    pin_a = 8'h7E;
    cyc(3);
    rd_chk(0, R_FLAG, "fall_flag", 8'h80);
    wr(0, R_FLAG, 8'h80);
    rd_chk(0, R_FLAG, "fall_clr", 8'h00);
    pin_a = 8'hFE;
    cyc(4);
    pin_a = 8'h7E;
    cyc(2);
    wr(0, R_FLAG, 8'h80);
    rd_chk(0, R_FLAG, "set_wins", 8'h80);
    wr(0, R_FLAG, 8'h00);
    rd_chk(0, R_FLAG, "w0_noeffect", 8'h80);
    wr(0, R_FLAG, 8'h80);
    rd_chk(0, R_FLAG, "fall_clr2", 8'h00);
    chk("fall_irq_clr", {7'b0, irq_a}, 8'h00);

    // 5: sleep gating
    pin_a = 8'h00;
    cyc(4);
    rd_chk(0, R_FLAG, "sleep_pre", 8'h00);
    wr(0, R_RISE, 8'h02);
    sleep = 1'b1;
    pin_a = 8'h02;
    cyc(3);
    rd_chk(0, R_FLAG, "sleep_wake", 8'h02);
    chk("sleep_irq", {7'b0, irq_a}, 8'h01);
    pin_a = 8'h06;
    cyc(4);
    rd_chk(0, R_PIN, "sleep_gated", 8'h02);
    rd_chk(0, R_FLAG, "sleep_noflag", 8'h02);
    sleep = 1'b0;
    cyc(3);
    rd_chk(0, R_PIN, "wake_pin", 8'h06);
    rd_chk(0, R_FLAG, "wake_noflag", 8'h02);

    // 6: narrow instance, PDW=4 SYN=3
    wr(1, R_DDR, 8'hFF);
    rd_chk(1, R_DDR, "b_ddr_mask", 8'h0F);
    chk("b_ddr_out", {4'h0, ddr_b}, 8'h0F);
    wr(1, R_RISE, 8'hFF);
    rd_chk(1, R_RISE, "b_rise_mask", 8'h0F);
    pin_b = 4'hA;
    cyc(2);
    rd_chk(1, R_PIN, "b_pin_early", 8'h00);
    cyc(1);
    rd_chk(1, R_PIN, "b_pin_syn", 8'h0A);
    rd_chk(1, R_FLAG, "b_flag_early", 8'h00);
    cyc(1);
    rd_chk(1, R_FLAG, "b_flag", 8'h0A);
    chk("b_irq", {7'b0, irq_b}, 8'h01);
    rd_m_chk(1, 6'b000011, "b_multihot", 8'h00);
    rd_m_chk(1, 6'b000000, "b_noread", 8'h00);

    // asynchronous reset mid-operation
    rst = 1'b0;
    #1;
    chk("arst_irq",  {7'b0, irq_a}, 8'h00);
    chk("arst_ddr",  ddr_a, 8'h00);
    chk("arst_irqb", {7'b0, irq_b}, 8'h00);
    rd_chk(0, R_FLAG, "arst_flag", 8'h00);
    rd_chk(0, R_PIN, "arst_pin", 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
